io_uart_tx: RTL
===============

Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter peripheral on the CPU IO bus.
- The CPU is the IO initiator; this block is the responder. An IO store to the data register queues one byte, and an IO load from the status register returns FIFO/busy flags.
- Bytes are serialized 8N1, LSB first, on a single TX line to the board's USB-UART bridge.
- Sits beside the LED and switch peripherals. It is selected by MemOrIO through a dedicated UARTCtrl strobe.

Parameters:
- CLKS_PER_BIT, 200, cpu clock cycles per UART bit (must be >= 2).
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8 entries.

Ports:
- clock  in  1  CPU clock (cpuclk output); all state updates on rising edge.
- reset  in  1  synchronous, active-low reset, sampled on rising edge of clock.
- UARTCtrl  in  1  peripheral select from MemOrIO address decode.
- ioWrite  in  1  IO store strobe, one cycle per sw.
- ioRead  in  1  IO load strobe, one cycle per lw.
- reg_sel  in  1  register select from ALU_Result[2]: 0 = DATA, 1 = STATUS.
- write_data  in  16  store data; only [7:0] are used.
- read_data  out  16  combinational load data; 16'h0000 when not (UARTCtrl && ioRead).
- tx  out  1  serial output, idle high.

Behaviour:
- Reset (reset==0 at an edge):
  - tx=1, FSM=IDLE, FIFO empty, wr/rd pointers=0, overflow=0, bit/baud counters=0.
  - Reset mid-frame aborts the frame immediately; tx is high after that edge.
- Push:
  - Condition: UARTCtrl && ioWrite && reg_sel==0.
  - If the FIFO is not full at that edge, write_data[7:0] is written at wr_ptr and wr_ptr increments, wrapping mod depth.
  - If the FIFO is full, the byte is dropped and overflow is set (sticky). Fullness is evaluated on pre-edge state, so a pop in the same cycle does not rescue the push.
- Count:
  - Kept in an FIFO_AW+1-bit counter.
  - full = (count==depth); empty = (count==0).
  - Simultaneous push and pop leaves count unchanged.
- Writes with reg_sel==1 are ignored.
- STATUS read (UARTCtrl && ioRead && reg_sel==1):
  - read_data = {8'h00, count padded to 4 bits, overflow, empty, full, busy}.
  - Layout: [0] busy, [1] full, [2] empty, [3] overflow, [7:4] count.
  - busy = (FSM != IDLE) || !empty.
  - overflow clears at the edge ending that read cycle; if a dropped push occurs in the same cycle, overflow stays 1.
- DATA read (UARTCtrl && ioRead && reg_sel==0): returns 16'h0000.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If !empty, pop the head byte into shift reg, clear baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right; after bit_idx==7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if !empty, pop and go directly to START (no idle gap between back-to-back frames); else go to IDLE.
- Latency:
  - Push at edge k → FIFO non-empty after k.
  - Pop at edge k+1 → tx=0 after k+1.
  - Frame length = 10*CLKS_PER_BIT cycles.
- tx is driven from a register; no combinational glitches.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.

Test Plan:
- Single byte (CLKS_PER_BIT=4): reset low 2 cycles, then push 8'hA5.
  - tx low 4 cycles after the pop edge.
  - Bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles.
  - busy=1 throughout, busy=0 after STOP.
- Back-to-back: push 8'h55 then 8'h0F on consecutive cycles.
  - 80 contiguous cycles of framing: stop bit of the first frame is followed immediately by the start bit of the second.
  - Decoded bytes are 55, 0F in order.
- Overflow: push 10 bytes 0x00..0x09 while the first is transmitting.
  - Byte 0 is popped at edge 2; bytes 1–8 fill the FIFO (count=8, full=1).
  - Byte 9 is dropped and STATUS reads 0x008B.
  - The following STATUS read shows overflow=0 (0x0083).
  - Serial output is 00..08 and never 09.
- Pointer wrap: send 20 bytes in bursts of 6, waiting for empty between bursts.
  - All 20 are received in order.
  - count returns to 0; STATUS reads 0x0004 when drained.
- Reset mid-frame: assert reset during DATA bit 3 of 8'hFF.
  - tx=1, STATUS=0x0004 after the edge.
  - A subsequent push of 8'h3C transmits correctly.
- Select gating: ioWrite with UARTCtrl=0, and ioWrite with reg_sel=1.
  - No FIFO change.
  - read_data=0 whenever UARTCtrl && ioRead is false.

Source files
------------

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: an 8-entry byte FIFO written by IO stores,
// drained LSB-first onto a registered tx line, with a STATUS register for polling.
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 200,
    parameter int FIFO_AW      = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        UARTCtrl,
    input  logic        ioWrite,
    input  logic        ioRead,
    input  logic        reg_sel,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        tx
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t             state_reg, state_next;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               overflow_reg, overflow_next;
    logic [BW-1:0]      baud_reg, baud_next;
    logic [2:0]         bit_idx_reg, bit_idx_next;
    logic [7:0]         shift_reg, shift_next;
    logic               tx_reg, tx_next;
    logic               full, empty, push_req, push, drop, pop, status_rd, busy;
    logic [7:0]         head;

    assign full      = (count_reg == DEPTH_CNT);
    assign empty     = (count_reg == '0);
    assign push_req  = UARTCtrl && ioWrite && !reg_sel;
    // Fullness is judged on pre-edge state: a same-cycle pop cannot rescue the push.
    assign push      = push_req && !full;
    assign drop      = push_req && full;
    assign status_rd = UARTCtrl && ioRead && reg_sel;
    assign busy      = (state_reg != ST_IDLE) || !empty;
    assign head      = mem[rd_ptr_reg];
    assign tx        = tx_reg;

    always_comb begin
        read_data = 16'h0000;
        if (status_rd) begin
            read_data = {8'h00, 4'(count_reg), overflow_reg, empty, full, busy};
        end
    end

    always_comb begin
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (status_rd) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= write_data[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            overflow_reg <= overflow_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
        end
    end

    // tx_next is the line level for the state being entered, so tx stays registered.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    baud_next  = '0;
                    state_next = ST_START;
                    tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = ST_DATA;
                    tx_next      = shift_reg[0];
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
                        state_next = ST_START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule
